// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement operands when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // RUN   | shifting out one quotient bit per edge, WIDTH edges total
    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;
    logic             dz;

    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sign_q;
    logic sign_r;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
        last   = (state == RUN) && (count == CW'(WIDTH - 1));

        // R is always below D, so its top bit is zero and the (WIDTH+2)-bit
        // difference's MSB is a clean borrow flag for the trial subtraction.
        trial = {r_reg, q_reg[WIDTH-1]} - {2'b00, d_reg};
        fits  = ~trial[WIDTH+1];
        r_nxt = fits ? trial[WIDTH:0] : {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        q_nxt = {q_reg[WIDTH-2:0], fits};

`ifdef SEQ_DIVIDER_SIGNED_EN
        mag_a      = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b      = divisor[WIDTH-1]  ? -divisor  : divisor;
        // Divide-by-zero must report all-ones regardless of the dividend sign.
        quot_final = dz ? {WIDTH{1'b1}} : (sign_q ? -q_nxt : q_nxt);
        rem_final  = sign_r ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0];
`else
        mag_a      = dividend;
        mag_b      = divisor;
        quot_final = q_nxt;
        rem_final  = r_nxt[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            done <= last;
            if (accept) begin
                q_reg <= mag_a;
                d_reg <= mag_b;
                r_reg <= '0;
                count <= '0;
                dz    <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                sign_r <= dividend[WIDTH-1];
`endif
            end else if (state == RUN) begin
                q_reg <= q_nxt;
                r_reg <= r_nxt;
                count <= count + 1'b1;
                if (last) begin
                    quotient    <= quot_final;
                    remainder   <= rem_final;
                    div_by_zero <= dz;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared every
// cycle, directed literal cases, then randomized start/operand traffic.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain division operators on the captured operands.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        if (b == '0) return {W{1'b1}};
`ifdef SEQ_DIVIDER_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return W'(sa / sb);
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        if (b == '0) return a;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return W'(sa % sb);
    endfunction

    // Transaction-level model: an accepted start produces done exactly W edges later.
    logic         m_busy, m_done, m_dz, p_dz;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_q <= '0; m_r <= '0; m_cnt <= 0;
            p_q <= '0; p_r <= '0; p_dz <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_dz   <= p_dz;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= W;
                p_q    <= ref_q(dividend, divisor);
                p_r    <= ref_r(dividend, divisor);
                p_dz   <= (divisor == '0);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_quotient", 32'(quotient), 32'(m_q));
        check("cyc_remainder", 32'(remainder), 32'(m_r));
        check("cyc_dz", 32'(div_by_zero), 32'(m_dz));
    end

    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 3 * W) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                                 input logic edz);
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int lat;
        launch(a, b);
        lat = 0;
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        expect_result(tag, eq, er, edz);
    endtask

    initial begin
        int lat;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_q", 32'(quotient), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b1;

        run_op("div_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_op("div_by_zero", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);

        // Back-to-back: start raised on the done cycle.
        launch(16'hFFFF, 16'h0001);
        lat = 0;
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'(W));
        expect_result("b2b_first", 16'hFFFF, 16'h0000, 1'b0);
        start = 1'b1; dividend = 16'hFFFF; divisor = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        check("b2b_restart_done", 32'(done), 32'h0);
        check("b2b_restart_busy", 32'(busy), 32'h1);
        check("b2b_hold_q", 32'(quotient), 32'hFFFF);
        lat = 0;
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'(W));
        expect_result("b2b_second", 16'h0001, 16'h0000, 1'b0);

        // start while busy is ignored.
        launch(16'd50, 16'd5);
        lat = 0;
        repeat (4) begin @(negedge clk); lat++; end
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(negedge clk); lat++;
        start = 1'b0;
        wait_done(lat);
        check("ignore_latency", 32'(lat), 32'(W));
        expect_result("ignore", 16'd10, 16'd0, 1'b0);

        // Reset mid-operation.
        launch(16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_q", 32'(quotient), 32'h0);
        check("midrst_r", 32'(remainder), 32'h0);
        check("midrst_dz", 32'(div_by_zero), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done === 1'b1) lat++;
        end
        check("midrst_no_done", 32'(lat), 32'h0);
        run_op("div_1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m7_2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("s_7_m2", 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
        run_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        run_op("s_neg_by_zero", 16'hFF00, 16'h0000, 16'hFFFF, 16'hFF00, 1'b1);
`endif

        // Random traffic: start toggles freely, so busy-time starts and
        // done-cycle restarts occur naturally.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            case ($urandom_range(0, 3))
                0:       divisor = '0;
                1:       divisor = W'($urandom_range(1, 15));
                default: divisor = W'($urandom);
            endcase
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
